regfile: RTL and testbench

//  GeMIPS general-purpose register file: 32 x 32-bit, one write port, two read ports.

---
 rtl/regfile.sv | 106 ++++++++++
 tb/tb_regfile.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// GeMIPS 32 x 32-bit register file with one write port and two read ports.
// Reads bypass a same-cycle write, and the file emits a registered commit trace and a commit counter.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic              dbg_we_o,
  output logic [ADDR_W-1:0] dbg_waddr_o,
  output logic [DATA_W-1:0] dbg_wdata_o,
  output logic [CNT_W-1:0]  commit_cnt_o
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int NPORTS = 2;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic commit;
  logic [DATA_W-1:0] regs [NREGS];

  assign commit = we_i && (waddr_i != '0) && !rst;

  // Storage is flops rather than block RAM because reset clears every entry in one cycle.
  for (genvar gi = 0; gi < NREGS; gi++) begin : gen_reg
    if (gi == 0) begin : gen_zero
      assign regs[gi] = '0;
    end else begin : gen_flop
      logic [DATA_W-1:0] q_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg <= '0;
        end else if (commit && (waddr_i == ADDR_W'(gi))) begin
          q_reg <= wdata_i;
        end
      end

      assign regs[gi] = q_reg;
    end
  end

  logic [NPORTS-1:0] re_vec;
  logic [ADDR_W-1:0] raddr_vec [NPORTS];

  assign re_vec       = {re2_i, re1_i};
  assign raddr_vec[0] = raddr1_i;
  assign raddr_vec[1] = raddr2_i;

  for (genvar gi = 0; gi < NPORTS; gi++) begin : gen_rd
    logic [DATA_W-1:0] data;

    // The $0 check comes before the bypass so a write to $0 never leaks onto a read port.
    always_comb begin
      data = '0;
      if (rst || !re_vec[gi] || (raddr_vec[gi] == '0)) begin
        data = '0;
      end else if (we_i && (raddr_vec[gi] == waddr_i)) begin
        data = wdata_i;
      end else begin
        data = regs[raddr_vec[gi]];
      end
    end
  end

  assign rdata1_o = gen_rd[0].data;
  assign rdata2_o = gen_rd[1].data;

  logic              dbg_we_reg;
  logic [ADDR_W-1:0] dbg_waddr_reg;
  logic [DATA_W-1:0] dbg_wdata_reg;
  logic [CNT_W-1:0]  commit_cnt_reg;

  // Address and data of the trace hold their last commit so a difftest can sample them lazily.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_we_reg     <= 1'b0;
      dbg_waddr_reg  <= '0;
      dbg_wdata_reg  <= '0;
      commit_cnt_reg <= '0;
    end else begin
      dbg_we_reg <= commit;
      if (commit) begin
        dbg_waddr_reg  <= waddr_i;
        dbg_wdata_reg  <= wdata_i;
        commit_cnt_reg <= commit_cnt_reg + CNT_ONE;
      end
    end
  end

  assign dbg_we_o     = dbg_we_reg;
  assign dbg_waddr_o  = dbg_waddr_reg;
  assign dbg_wdata_o  = dbg_wdata_reg;
  assign commit_cnt_o = commit_cnt_reg;

endmodule

// File: tb/tb_regfile.sv
// Directed testbench for regfile: reset, write/read, bypass, $0, reset-drop, read enable, counter wrap.
// A second instance with a 4-bit counter shares the stimulus to exercise the wrap.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;

  logic [31:0] rdata1, rdata2, dbg_wdata, commit_cnt;
  logic        dbg_we;
  logic [4:0]  dbg_waddr;

  logic [31:0] s_rdata1, s_rdata2, s_dbg_wdata;
  logic        s_dbg_we;
  logic [4:0]  s_dbg_waddr;
  logic [3:0]  s_commit_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile dut (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .re1_i(re1), .raddr1_i(raddr1), .rdata1_o(rdata1),
    .re2_i(re2), .raddr2_i(raddr2), .rdata2_o(rdata2),
    .dbg_we_o(dbg_we), .dbg_waddr_o(dbg_waddr), .dbg_wdata_o(dbg_wdata),
    .commit_cnt_o(commit_cnt)
  );

  regfile #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .re1_i(re1), .raddr1_i(raddr1), .rdata1_o(s_rdata1),
    .re2_i(re2), .raddr2_i(raddr2), .rdata2_o(s_rdata2),
    .dbg_we_o(s_dbg_we), .dbg_waddr_o(s_dbg_waddr), .dbg_wdata_o(s_dbg_wdata),
    .commit_cnt_o(s_commit_cnt)
  );

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later, mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h99;
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd9; raddr2 = 5'd9;
    settle();
    tests++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      fails++;
      $display("FAIL reset_read_during_rst: rdata1=%h rdata2=%h required 0", rdata1, rdata2);
    end
    tick();
    rst = 1'b0; we = 1'b0;
    for (int r = 1; r < 32; r++) begin
      raddr1 = r[4:0]; raddr2 = 5'(31 - r + 1);
      settle();
      tests++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        fails++;
        $display("FAIL reset_clear r%0d/r%0d: rdata1=%h rdata2=%h required 0", r, 32 - r, rdata1, rdata2);
      end
    end
    tests++;
    if (commit_cnt !== 32'd0 || dbg_we !== 1'b0 || dbg_waddr !== 5'd0 || dbg_wdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: cnt=%0d dbg_we=%b dbg_waddr=%0d dbg_wdata=%h required 0", commit_cnt, dbg_we, dbg_waddr, dbg_wdata);
    end
    $display("[TB] reset: registers, trace and counter checked");
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    re1 = 1'b1; raddr1 = 5'd1; re2 = 1'b1; raddr2 = 5'd2;
    tick();
    we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
    settle();
    tests++;
    if (rdata1 !== 32'hDEADBEEF || rdata2 !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL write_read r5: rdata1=%h rdata2=%h required deadbeef", rdata1, rdata2);
    end
    tests++;
    if (dbg_we !== 1'b1 || dbg_waddr !== 5'd5 || dbg_wdata !== 32'hDEADBEEF || commit_cnt !== 32'd1) begin
      fails++;
      $display("FAIL write_trace: dbg_we=%b waddr=%0d wdata=%h cnt=%0d required 1/5/deadbeef/1", dbg_we, dbg_waddr, dbg_wdata, commit_cnt);
    end
    tick();
    tests++;
    if (dbg_we !== 1'b0 || dbg_waddr !== 5'd5 || dbg_wdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL trace_hold: dbg_we=%b waddr=%0d wdata=%h required 0/5/deadbeef", dbg_we, dbg_waddr, dbg_wdata);
    end
    $display("[TB] write_read: r5 <= deadbeef, read back next cycle");
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7;
    settle();
    tests++;
    if (rdata1 !== 32'h12345678 || rdata2 !== 32'h12345678) begin
      fails++;
      $display("FAIL bypass_same_cycle: rdata1=%h rdata2=%h required 12345678", rdata1, rdata2);
    end
    raddr2 = 5'd5;
    settle();
    tests++;
    if (rdata1 !== 32'h12345678 || rdata2 !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL bypass_one_port: rdata1=%h rdata2=%h required 12345678/deadbeef", rdata1, rdata2);
    end
    tick();
    we = 1'b0; raddr2 = 5'd7;
    settle();
    tests++;
    if (rdata1 !== 32'h12345678 || rdata2 !== 32'h12345678 || commit_cnt !== 32'd2) begin
      fails++;
      $display("FAIL bypass_stored: rdata1=%h rdata2=%h cnt=%0d required 12345678/12345678/2", rdata1, rdata2, commit_cnt);
    end
    $display("[TB] bypass: r7 <= 12345678 visible same cycle on both ports");
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0;
    settle();
    tests++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      fails++;
      $display("FAIL zero_same_cycle: rdata1=%h rdata2=%h required 0", rdata1, rdata2);
    end
    tick();
    we = 1'b0;
    settle();
    tests++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      fails++;
      $display("FAIL zero_next_cycle: rdata1=%h rdata2=%h required 0", rdata1, rdata2);
    end
    tests++;
    if (dbg_we !== 1'b0 || dbg_waddr !== 5'd7 || dbg_wdata !== 32'h12345678 || commit_cnt !== 32'd2) begin
      fails++;
      $display("FAIL zero_trace: dbg_we=%b waddr=%0d wdata=%h cnt=%0d required 0/7/12345678/2", dbg_we, dbg_waddr, dbg_wdata, commit_cnt);
    end
    $display("[TB] zero_reg: write to $0 ignored");
  endtask

  task automatic test_reset_drop();
    we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
    tick();
    rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h44444444;
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd3; raddr2 = 5'd4;
    settle();
    tests++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      fails++;
      $display("FAIL reset_read_zero: rdata1=%h rdata2=%h required 0", rdata1, rdata2);
    end
    tick();
    rst = 1'b0; we = 1'b0;
    settle();
    tests++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      fails++;
      $display("FAIL reset_drop r3/r4: rdata1=%h rdata2=%h required 0", rdata1, rdata2);
    end
    tests++;
    if (commit_cnt !== 32'd0 || dbg_we !== 1'b0 || dbg_waddr !== 5'd0 || dbg_wdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_drop_trace: cnt=%0d dbg_we=%b waddr=%0d wdata=%h required 0", commit_cnt, dbg_we, dbg_waddr, dbg_wdata);
    end
    $display("[TB] reset_drop: r3 cleared, r4 write under reset dropped");
  endtask

  task automatic test_read_enable();
    we = 1'b1; waddr = 5'd3; wdata = 32'h11;
    tick();
    we = 1'b0;
    re1 = 1'b0; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
    settle();
    tests++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h11) begin
      fails++;
      $display("FAIL read_enable1: rdata1=%h rdata2=%h required 0/11", rdata1, rdata2);
    end
    re1 = 1'b1; re2 = 1'b0;
    settle();
    tests++;
    if (rdata1 !== 32'h11 || rdata2 !== 32'h0) begin
      fails++;
      $display("FAIL read_enable2: rdata1=%h rdata2=%h required 11/0", rdata1, rdata2);
    end
    we = 1'b1; waddr = 5'd3; wdata = 32'h77;
    settle();
    tests++;
    if (rdata1 !== 32'h77 || rdata2 !== 32'h0) begin
      fails++;
      $display("FAIL read_enable_bypass: rdata1=%h rdata2=%h required 77/0", rdata1, rdata2);
    end
    we = 1'b0; re2 = 1'b1;
    $display("[TB] read_enable: disabled ports read 0");
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      we = 1'b1; waddr = 5'(i + 8); wdata = 32'hC0DE0000 + 32'(i);
      tick();
    end
    we = 1'b0;
    settle();
    tests++;
    if (s_commit_cnt !== 4'd0 || commit_cnt !== 32'd16) begin
      fails++;
      $display("FAIL counter_wrap: small=%0d wide=%0d required 0/16", s_commit_cnt, commit_cnt);
    end
    tests++;
    if (dbg_we !== 1'b1 || dbg_waddr !== 5'd24 || dbg_wdata !== 32'hC0DE0010) begin
      fails++;
      $display("FAIL b2b_trace: dbg_we=%b waddr=%0d wdata=%h required 1/24/c0de0010", dbg_we, dbg_waddr, dbg_wdata);
    end
    for (int i = 1; i <= 16; i++) begin
      raddr1 = 5'(i + 8); raddr2 = 5'(25 - i);
      settle();
      tests++;
      if (rdata1 !== 32'hC0DE0000 + 32'(i) || rdata2 !== 32'hC0DE0000 + 32'(17 - i)) begin
        fails++;
        $display("FAIL b2b_read r%0d/r%0d: rdata1=%h rdata2=%h required %h/%h", i + 8, 25 - i, rdata1, rdata2, 32'hC0DE0000 + 32'(i), 32'hC0DE0000 + 32'(17 - i));
      end
    end
    $display("[TB] back_to_back: 16 commits, 4-bit counter wrapped");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_reset_drop();
    test_read_enable();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
